// File: rtl/fruitninja_vga_pkg.sv
// Shared types and constants for the fruit-ninja VGA pixel pipeline.
package fruitninja_vga_pkg;

    typedef logic [9:0] coord_t;
    typedef logic [3:0] pal_index_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam pal_index_t TRANSPARENT_INDEX = 4'd0;

    // Half-open span test on widened coordinates so lo+size cannot wrap.
    function automatic logic in_span(input logic [10:0] v, input logic [10:0] lo,
                                     input logic [10:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/start_text_sprite_fetch_if.sv
// Scan-position, sprite-ROM and palette-side signals of the start-text fetch stage.
interface start_text_sprite_fetch_if
    import fruitninja_vga_pkg::*;
#(
    parameter int ADDR_W = 14
) ();

    coord_t             draw_x;
    coord_t             draw_y;
    logic               de;
    logic               frame_start;
    logic               show;
    logic [ADDR_W-1:0]  rom_addr;
    pal_index_t         rom_q;
    pal_index_t         pix_index;
    logic               pix_valid;
    logic               de_d;
    logic               blink_on;

    modport master (
        output draw_x, draw_y, de, frame_start, show, rom_q,
        input  rom_addr, pix_index, pix_valid, de_d, blink_on
    );

    modport slave (
        input  draw_x, draw_y, de, frame_start, show, rom_q,
        output rom_addr, pix_index, pix_valid, de_d, blink_on
    );

endinterface

// File: rtl/start_text_sprite_fetch_blink_timer.sv
// Frame-counted blink phase generator; held visible while disabled.
module blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset_n,
    input  logic frame_start,
    input  logic enable,
    output logic blink_on
);

    localparam int CNT_W  = (BLINK_FRAMES > 0) ? $clog2(BLINK_FRAMES + 1) : 1;
    localparam int LAST_I = (BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_I);

    logic [CNT_W-1:0] cnt_r;
    logic             blink_r;

    // Blink counter and phase; disable wins over a coincident frame pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r   <= {CNT_W{1'b0}};
            blink_r <= 1'b1;
        end else if (!enable || (BLINK_FRAMES == 0)) begin
            cnt_r   <= {CNT_W{1'b0}};
            blink_r <= 1'b1;
        end else if (frame_start) begin
            if (cnt_r == LAST) begin
                cnt_r   <= {CNT_W{1'b0}};
                blink_r <= ~blink_r;
            end else begin
                cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r   <= cnt_r;
            blink_r <= blink_r;
        end
    end

    assign blink_on = blink_r;

endmodule

// File: rtl/start_text_sprite_fetch.sv
// Turns the scan position into a sprite-ROM address and aligns the ROM index
// with validity, blink and a delayed display-enable (2-clock latency).
module start_text_sprite_fetch
    import fruitninja_vga_pkg::*;
#(
    parameter int         TEXT_W       = 256,
    parameter int         TEXT_H       = 64,
    parameter int         POS_X        = 192,
    parameter int         POS_Y        = 208,
    parameter int         ADDR_W       = 14,
    parameter int         BLINK_FRAMES = 30,
    parameter pal_index_t KEY_INDEX    = TRANSPARENT_INDEX
) (
    input  logic                      clk,
    input  logic                      reset_n,
    start_text_sprite_fetch_if.slave  bus
);

    localparam int XB = $clog2(TEXT_W);
    localparam int YB = $clog2(TEXT_H);
    localparam logic [10:0] X_LO = 11'(POS_X);
    localparam logic [10:0] X_HI = 11'(POS_X + TEXT_W);
    localparam logic [10:0] Y_LO = 11'(POS_Y);
    localparam logic [10:0] Y_HI = 11'(POS_Y + TEXT_H);

    logic [10:0]       x_s;
    logic [10:0]       y_s;
    logic [XB-1:0]     col_s;
    logic [YB-1:0]     row_s;
    logic              in_box_s;
    logic [ADDR_W-1:0] addr_s;
    logic              blink_on_s;

    logic [ADDR_W-1:0] rom_addr_r;
    logic              in_box_d1_r, de_d1_r, show_d1_r, blink_d1_r;
    logic              in_box_d2_r, de_d2_r, show_d2_r, blink_d2_r;

    logic              pix_valid_s;
    pal_index_t        pix_index_s;

    blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (bus.frame_start),
        .enable      (bus.show),
        .blink_on    (blink_on_s)
    );

    // Stage 0: box test and sprite-local address; TEXT_W is a power of two so
    // the column bits concatenate directly under the row bits.
    always_comb begin
        x_s      = {1'b0, bus.draw_x};
        y_s      = {1'b0, bus.draw_y};
        col_s    = XB'(x_s - X_LO);
        row_s    = YB'(y_s - Y_LO);
        in_box_s = in_span(x_s, X_LO, X_HI) && in_span(y_s, Y_LO, Y_HI);
        if (in_box_s) begin
            addr_s = ADDR_W'({row_s, col_s});
        end else begin
            addr_s = {ADDR_W{1'b0}};
        end
    end

    // Stages 1 and 2: ROM address plus the side bits that travel with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr_r  <= {ADDR_W{1'b0}};
            in_box_d1_r <= 1'b0;
            de_d1_r     <= 1'b0;
            show_d1_r   <= 1'b0;
            blink_d1_r  <= 1'b0;
            in_box_d2_r <= 1'b0;
            de_d2_r     <= 1'b0;
            show_d2_r   <= 1'b0;
            blink_d2_r  <= 1'b0;
        end else begin
            rom_addr_r  <= addr_s;
            in_box_d1_r <= in_box_s;
            de_d1_r     <= bus.de;
            show_d1_r   <= bus.show;
            blink_d1_r  <= blink_on_s;
            in_box_d2_r <= in_box_d1_r;
            de_d2_r     <= de_d1_r;
            show_d2_r   <= show_d1_r;
            blink_d2_r  <= blink_d1_r;
        end
    end

    // Output qualify: the ROM's own output register closes stage 2.
    always_comb begin
        pix_valid_s = in_box_d2_r & de_d2_r & show_d2_r & blink_d2_r &
                      (bus.rom_q != KEY_INDEX);
        if (pix_valid_s) begin
            pix_index_s = bus.rom_q;
        end else begin
            pix_index_s = 4'd0;
        end
    end

    assign bus.rom_addr  = rom_addr_r;
    assign bus.pix_valid = pix_valid_s;
    assign bus.pix_index = pix_index_s;
    assign bus.de_d      = de_d2_r;
    assign bus.blink_on  = blink_on_s;

endmodule

// File: tb/tb_start_text_sprite_fetch.sv
// Table-driven, scoreboarded bench for start_text_sprite_fetch.
module tb_start_text_sprite_fetch;

    logic clk;
    logic reset_n;
    logic key_mode;
    logic key_d1;

    start_text_sprite_fetch_if #(.ADDR_W(14)) bus ();

    start_text_sprite_fetch dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM model: content is addr[3:0]+5, or all-key when key_mode was set.
    always @(posedge clk) begin
        key_d1    <= key_mode;
        bus.rom_q <= key_d1 ? 4'd0 : (bus.rom_addr[3:0] + 4'd5);
    end

    typedef struct {
        logic [3:0] idx;
        logic       valid;
        logic       de;
    } exp_t;

    typedef struct {
        int         x;
        int         y;
        logic       de;
        logic       sh;
        logic       key;
        logic [13:0] addr;
        logic [3:0] idx;
        logic       valid;
    } vec_t;

    exp_t        q[$];
    vec_t        tbl[14];
    logic [13:0] prev_addr;
    bit          prev_ok;
    logic        m_blink;
    int          m_cnt;
    int          n_vec;
    int          n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One pixel per call, entered and left at a falling edge.
    task automatic step(input int x, input int y, input logic de, input logic sh,
                        input logic fs, input logic key, input logic [13:0] eaddr,
                        input logic [3:0] eidx, input logic ev);
        exp_t e;
        if (q.size() == 2) e = q.pop_front();
        else e = '{idx: 4'd0, valid: 1'b0, de: 1'b0};
        check("pix_index", 32'(bus.pix_index), 32'(e.idx));
        check("pix_valid", 32'(bus.pix_valid), 32'(e.valid));
        check("de_d", 32'(bus.de_d), 32'(e.de));
        if (prev_ok) check("rom_addr", 32'(bus.rom_addr), 32'(prev_addr));
        check("blink_on", 32'(bus.blink_on), 32'(m_blink));
        bus.draw_x      = 10'(x);
        bus.draw_y      = 10'(y);
        bus.de          = de;
        bus.show        = sh;
        bus.frame_start = fs;
        key_mode        = key;
        q.push_back('{idx: eidx, valid: ev, de: de});
        prev_addr = eaddr;
        prev_ok   = 1'b1;
        if (!sh) begin
            m_cnt   = 0;
            m_blink = 1'b1;
        end else if (fs) begin
            if (m_cnt == 29) begin
                m_cnt   = 0;
                m_blink = ~m_blink;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        @(negedge clk);
    endtask

    // A frame pulse in blanking followed by one visible pixel at sprite origin.
    task automatic pulse(input logic sh);
        step(700, 490, 1'b0, sh, 1'b1, 1'b0, 14'd0, 4'd0, 1'b0);
        step(192, 208, 1'b1, 1'b1, 1'b0, 1'b0, 14'd0, m_blink ? 4'd5 : 4'd0, m_blink);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        prev_ok = 1'b0;
        prev_addr = 14'd0;
        m_blink = 1'b1;
        m_cnt = 0;
        key_mode = 1'b0;
        reset_n = 1'b0;
        bus.draw_x = 10'd0;
        bus.draw_y = 10'd0;
        bus.de = 1'b0;
        bus.show = 1'b0;
        bus.frame_start = 1'b0;

        //            x    y   de    sh    key   addr       idx    valid
        tbl[0]  = '{192, 208, 1'b1, 1'b1, 1'b0, 14'd0,     4'h5, 1'b1};
        tbl[1]  = '{447, 271, 1'b1, 1'b1, 1'b0, 14'd16383, 4'h4, 1'b1};
        tbl[2]  = '{448, 271, 1'b1, 1'b1, 1'b0, 14'd0,     4'h0, 1'b0};
        tbl[3]  = '{191, 208, 1'b1, 1'b1, 1'b0, 14'd0,     4'h0, 1'b0};
        tbl[4]  = '{192, 207, 1'b1, 1'b1, 1'b0, 14'd0,     4'h0, 1'b0};
        tbl[5]  = '{192, 272, 1'b1, 1'b1, 1'b0, 14'd0,     4'h0, 1'b0};
        tbl[6]  = '{200, 210, 1'b0, 1'b1, 1'b0, 14'd520,   4'h0, 1'b0};
        tbl[7]  = '{200, 210, 1'b1, 1'b1, 1'b1, 14'd520,   4'h0, 1'b0};
        tbl[8]  = '{203, 208, 1'b1, 1'b1, 1'b0, 14'd11,    4'h0, 1'b0};
        tbl[9]  = '{700, 210, 1'b1, 1'b1, 1'b0, 14'd0,     4'h0, 1'b0};
        tbl[10] = '{300, 250, 1'b1, 1'b0, 1'b0, 14'd10860, 4'h0, 1'b0};
        tbl[11] = '{300, 250, 1'b1, 1'b1, 1'b0, 14'd10860, 4'h1, 1'b1};
        tbl[12] = '{0,   0,   1'b1, 1'b1, 1'b0, 14'd0,     4'h0, 1'b0};
        tbl[13] = '{255, 239, 1'b1, 1'b1, 1'b0, 14'd7999,  4'h4, 1'b1};

        repeat (2) @(negedge clk);
        check("reset_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("reset_pix_valid", 32'(bus.pix_valid), 32'd0);
        check("reset_pix_index", 32'(bus.pix_index), 32'd0);
        check("reset_de_d", 32'(bus.de_d), 32'd0);
        check("reset_blink_on", 32'(bus.blink_on), 32'd1);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].x, tbl[i].y, tbl[i].de, tbl[i].sh, 1'b0, tbl[i].key,
                 tbl[i].addr, tbl[i].idx, tbl[i].valid);
        end

        for (int i = 0; i < 30; i++) pulse(1'b1);
        check("blink_off_after_30", 32'(bus.blink_on), 32'd0);
        for (int i = 0; i < 30; i++) pulse(1'b1);
        check("blink_on_after_60", 32'(bus.blink_on), 32'd1);
        for (int i = 0; i < 30; i++) pulse(1'b1);

        // Mid-stream reset while blink is off and de_d is high.
        repeat (3) step(300, 250, 1'b1, 1'b1, 1'b0, 1'b0, 14'd10860, 4'h0, 1'b0);
        check("pre_reset_de_d", 32'(bus.de_d), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("async_de_d", 32'(bus.de_d), 32'd0);
        check("async_pix_valid", 32'(bus.pix_valid), 32'd0);
        check("async_pix_index", 32'(bus.pix_index), 32'd0);
        check("async_blink_on", 32'(bus.blink_on), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        q.delete();
        prev_ok = 1'b0;
        m_blink = 1'b1;
        m_cnt = 0;
        repeat (4) step(300, 250, 1'b1, 1'b1, 1'b0, 1'b0, 14'd10860, 4'h1, 1'b1);

        // show drops exactly on frame pulse #29: timer restarts, no toggle.
        for (int i = 0; i < 28; i++) pulse(1'b1);
        pulse(1'b0);
        check("no_toggle_on_show_drop", 32'(bus.blink_on), 32'd1);
        for (int i = 0; i < 29; i++) pulse(1'b1);
        check("still_on_after_29", 32'(bus.blink_on), 32'd1);
        pulse(1'b1);
        check("off_after_30_more", 32'(bus.blink_on), 32'd0);

        repeat (3) step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 14'd0, 4'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/start_text_sprite_fetch.md
Name: start_text_sprite_fetch

Overview:
- Pixel-pipeline stage that sits directly upstream of the start-screen text palette lookup.
- Takes the VGA scan position and turns it into a sprite-ROM address.
- Aligns the ROM's 4-bit index output with a validity flag and a delayed display-enable, so the downstream palette and colour mux see matched data.
- Adds frame-counted blinking of the "start" text, gated by the game FSM.

Parameters:
- TEXT_W, 256, sprite width in pixels; must be a power of two.
- TEXT_H, 64, sprite height in pixels.
- POS_X, 192, screen x of the sprite's left column.
- POS_Y, 208, screen y of the sprite's top row.
- ADDR_W, 14, ROM address width; equals log2(TEXT_W*TEXT_H).
- BLINK_FRAMES, 30, frames per blink half-period; 0 disables blinking.
- KEY_INDEX, 0, palette index treated as transparent.

Ports:
- clk  in  1  pixel clock (25 MHz VGA domain)
- reset_n  in  1  asynchronous, active-low reset
- draw_x  in  10  current scan column, 0..799
- draw_y  in  10  current scan row, 0..524
- de  in  1  display enable (active video)
- frame_start  in  1  one-cycle pulse per frame, issued in vertical blank
- show  in  1  text enable from game FSM (level)
- rom_addr  out  ADDR_W  address to external synchronous sprite ROM (1-cycle read latency)
- rom_q  in  4  ROM data, valid one cycle after rom_addr
- pix_index  out  4  palette index to palette stage
- pix_valid  out  1  index is opaque, visible text
- de_d  out  1  de delayed to align with pix_index
- blink_on  out  1  current blink phase

Behaviour:
- Reset: asynchronous on reset_n low.
  - Reset values: rom_addr=0, all pipeline registers=0, pix_valid=0, pix_index=0, de_d=0, blink counter=0, blink_on=1.
- Stage 0 (combinational on inputs):
  - in_box = (draw_x >= POS_X) && (draw_x < POS_X+TEXT_W) && (draw_y >= POS_Y) && (draw_y < POS_Y+TEXT_H).
  - Compares use 11-bit arithmetic, so POS+size never wraps.
- Stage 1 (registered):
  - rom_addr <= in_box ? {(draw_y-POS_Y)[log2 TEXT_H-1:0], (draw_x-POS_X)[log2 TEXT_W-1:0]} : 0.
  - Pipe bits registered: in_box, de, show, blink_on.
- Stage 2:
  - ROM register presents rom_q.
  - Stage-1 bits are registered again, giving *_d2.
- Outputs (combinational from stage-2 registers and rom_q):
  - pix_valid = in_box_d2 & de_d2 & show_d2 & blink_on_d2 & (rom_q != KEY_INDEX).
  - pix_index = pix_valid ? rom_q : 0.
  - de_d = de_d2.
- Latency: exactly 2 clocks from draw_x/draw_y/de to pix_index/pix_valid/de_d. Throughput is 1 pixel per clock, with no stalls.
- Blink timer:
  - show=0: counter <= 0, blink_on <= 1, so text is visible on the first frame after show rises.
  - show=1 and frame_start=1: if counter == BLINK_FRAMES-1 then counter <= 0 and blink_on toggles; else counter increments.
  - BLINK_FRAMES=0: blink_on held at 1; the counter is unused.
  - Counter width is clog2(BLINK_FRAMES+1).
- Simultaneous events:
  - show falling with frame_start in the same cycle: show wins, so the timer resets and no toggle occurs.
  - blink_on is sampled per pixel into the pipe, so a toggle never splits a visible line; frame_start occurs only in blanking.
- Coordinate edges:
  - draw_x = POS_X+TEXT_W-1 is inside the box; POS_X+TEXT_W is outside.
  - Blanking coordinates (x>=640) are outside whenever POS_X+TEXT_W <= 640.
- Reset mid-line: pipeline flushes to zero immediately; the first valid output comes 2 clocks after reset_n rises.

Decomposition:
- Package fruitninja_vga_pkg holds:
  - coord_t (logic[9:0]) and pal_index_t (logic[3:0]);
  - SCREEN_W=640 and SCREEN_H=480;
  - TRANSPARENT_INDEX=0.
- Sub-module blink_timer (inputs clk, reset_n, frame_start, enable; output blink_on; parameter BLINK_FRAMES) is natural and reusable for the game-over text.

Test Plan:
- Reset, then draw_x=192, draw_y=208, de=1, show=1, ROM model returns 4'h5 at address 0 -> rom_addr=0 after 1 clock; pix_index=5, pix_valid=1, de_d=1 after 2 clocks.
- draw_x=447, draw_y=271 -> rom_addr=16383. Then draw_x=448 -> rom_addr=0, and two clocks later pix_valid=0, pix_index=0.
- ROM returns KEY_INDEX=0 inside the box -> pix_valid=0, pix_index=0; de_d still follows de with 2-clock delay.
- show=1 with 30 frame_start pulses -> blink_on falls after the 30th; 30 more pulses -> rises. Visible-box pixels read pix_valid=0 during the off phase.
- Pulse show low coincident with frame_start #29 -> no toggle; blink_on=1 and counter=0. Re-raise show -> toggle after 30 further frames.
- Assert reset_n=0 mid-stream -> outputs go to 0 asynchronously within the same cycle and blink_on=1. After release, valid data resumes at exactly +2 clocks.
